// File: rtl/dm_responder.sv
// Word-organised data-memory target with programmable wait states, byte-enable
// stores and fault signalling, answered over a req/ready/rvalid handshake.
module dm_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  be,
    output logic        ready,
    output logic        rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [1:0]  fsm_state
);

    // Handshake: a request is taken on a rising edge where ready=1 and req=1.
    // ready is high only in IDLE, so exactly one request is ever outstanding;
    // rvalid pulses for one cycle carrying rdata/err, then the next edge
    // returns to IDLE. Requests presented while ready=0 are not queued.

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam int         DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic [3:0]  lat_be;
    logic [31:0] mem [DEPTH];

    logic                  op_we;
    logic [31:0]           op_addr;
    logic [31:0]           op_wdata;
    logic [3:0]            op_be;
    logic [ADDR_WIDTH-1:0] idx;
    logic                  fault;
    logic                  enter_resp;

    // With LATENCY=1 the response is produced on the accepting edge itself,
    // so the operands come straight from the inputs instead of the latches.
    always_comb begin
        op_we      = (state == IDLE) ? we    : lat_we;
        op_addr    = (state == IDLE) ? addr  : lat_addr;
        op_wdata   = (state == IDLE) ? wdata : lat_wdata;
        op_be      = (state == IDLE) ? be    : lat_be;
        idx        = op_addr[ADDR_WIDTH+1:2];
        fault      = (op_addr[1:0] != 2'b00) || (op_addr[31:ADDR_WIDTH+2] != '0);
        enter_resp = ((state == BUSY) && (cnt == 4'd1))
                  || ((LATENCY == 1) && (state == IDLE) && req);
        ready      = reset && (state == IDLE);
        fsm_state  = state;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_we    <= we;
                        lat_addr  <= addr;
                        lat_wdata <= wdata;
                        lat_be    <= be;
                        cnt       <= CNT_INIT;
                        state     <= (LATENCY == 1) ? RESP : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end else if (enter_resp) begin
            rvalid <= 1'b1;
            err    <= fault;
            rdata  <= (!fault && !op_we) ? mem[idx] : 32'h0;
        end else begin
            rvalid <= 1'b0;
            err    <= 1'b0;
            rdata  <= '0;
        end
    end

    // Stores commit on the RESP-entry edge, ahead of any later load.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (enter_resp && op_we && !fault) begin
            for (int b = 0; b < 4; b++) begin
                if (op_be[b]) mem[idx][8*b +: 8] <= op_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=2 instance (a) and a LATENCY=1 instance (b)
// share clock and reset; each task drives one scenario and checks inline.
module tb_dm_responder;

    logic        clk;
    logic        reset;
    logic        req_a, we_a, ready_a, rvalid_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic [3:0]  be_a;
    logic [1:0]  st_a;
    logic        req_b, we_b, ready_b, rvalid_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;
    logic [3:0]  be_b;
    logic [1:0]  st_b;

    int n_checks = 0;
    int n_pass   = 0;

    dm_responder #(.ADDR_WIDTH(10), .LATENCY(2)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .we(we_a), .addr(addr_a),
        .wdata(wdata_a), .be(be_a), .ready(ready_a), .rvalid(rvalid_a),
        .rdata(rdata_a), .err(err_a), .fsm_state(st_a)
    );

    dm_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .we(we_b), .addr(addr_b),
        .wdata(wdata_b), .be(be_b), .ready(ready_b), .rvalid(rvalid_b),
        .rdata(rdata_b), .err(err_b), .fsm_state(st_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input bit sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        if (sel) begin
            req_b = r; we_b = w; addr_b = a; wdata_b = d; be_b = b;
        end else begin
            req_a = r; we_a = w; addr_a = a; wdata_a = d; be_a = b;
        end
    endtask

    // One request; lat counts edges from the accepting edge (inclusive) to rvalid.
    task automatic txn(input bit sel, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output logic [31:0] rd, output logic e, output int lat);
        int   guard;
        logic rv, rdy, bad_ready;
        guard = 0;
        while (!(sel ? ready_b : ready_a) && guard < 20) begin
            @(posedge clk); #1; guard++;
        end
        drive(sel, 1'b1, w, a, d, b);
        lat = 0; rv = 1'b0; bad_ready = 1'b0; rd = '0; e = 1'b0;
        while (!rv && lat < 20) begin
            @(posedge clk); #1; lat++;
            if (lat == 1) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
            rv  = sel ? rvalid_b : rvalid_a;
            rdy = sel ? ready_b  : ready_a;
            if (rdy) bad_ready = 1'b1;
        end
        rd = sel ? rdata_b : rdata_a;
        e  = sel ? err_b   : err_a;
        n_checks++;
        if (bad_ready !== 1'b0) $display("FAIL ready_while_busy addr=%h got=1 exp=0", a);
        else n_pass++;
        @(posedge clk); #1;
        n_checks++;
        if ((sel ? rvalid_b : rvalid_a) !== 1'b0 || (sel ? ready_b : ready_a) !== 1'b1)
            $display("FAIL resp_one_cycle addr=%h rvalid=%b ready=%b exp rvalid=0 ready=1",
                     a, sel ? rvalid_b : rvalid_a, sel ? ready_b : ready_a);
        else n_pass++;
    endtask

    // Holds req high across two request patterns and records acceptance cycles.
    task automatic run_held(input bit sel, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
                            input logic w2, input logic [31:0] a2, input logic [31:0] d2,
                            output int c0, output int c1, output int pulses, output logic [31:0] last_rd);
        int acc;
        acc = 0; c0 = -1; c1 = -1; pulses = 0; last_rd = '0;
        drive(sel, 1'b1, w1, a1, d1, 4'hF);
        for (int c = 0; c < 8; c++) begin
            if ((sel ? ready_b : ready_a) && acc < 2) begin
                if (acc == 0) c0 = c; else c1 = c;
                acc++;
            end
            @(posedge clk); #1;
            if (sel ? rvalid_b : rvalid_a) begin
                pulses++;
                last_rd = sel ? rdata_b : rdata_a;
            end
            if (acc == 1) drive(sel, 1'b1, w2, a2, d2, 4'hF);
            else if (acc == 2) drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (ready_a !== 1'b0) $display("FAIL rst_ready got=%b exp=0", ready_a); else n_pass++;
        n_checks++; if (rvalid_a !== 1'b0) $display("FAIL rst_rvalid got=%b exp=0", rvalid_a); else n_pass++;
        n_checks++; if (err_a !== 1'b0) $display("FAIL rst_err got=%b exp=0", err_a); else n_pass++;
        n_checks++; if (rdata_a !== 32'h0) $display("FAIL rst_rdata got=%h exp=0", rdata_a); else n_pass++;
        n_checks++; if (st_a !== 2'd0) $display("FAIL rst_state got=%0d exp=0", st_a); else n_pass++;
        @(negedge clk); reset = 1'b1; #1;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL rst_release_ready got=%b exp=1", ready_a); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic e; int lat;
        txn(1'b0, 1'b1, 32'h4, 32'h1234_5678, 4'hF, rd, e, lat);
        n_checks++; if (lat !== 2) $display("FAIL st_latency got=%0d exp=2", lat); else n_pass++;
        n_checks++; if (e !== 1'b0 || rd !== 32'h0) $display("FAIL st_resp err=%b rdata=%h exp err=0 rdata=0", e, rd); else n_pass++;
        txn(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (lat !== 2) $display("FAIL ld_latency got=%0d exp=2", lat); else n_pass++;
        n_checks++; if (rd !== 32'h1234_5678) $display("FAIL ld_data got=%h exp=12345678", rd); else n_pass++;
        n_checks++; if (e !== 1'b0) $display("FAIL ld_err got=%b exp=0", e); else n_pass++;
    endtask

    task automatic test_byte_enables();
        logic [31:0] rd; logic e; int lat;
        txn(1'b0, 1'b1, 32'h8, 32'hAABB_CCDD, 4'hF, rd, e, lat);
        txn(1'b0, 1'b1, 32'h8, 32'h1122_3344, 4'b0101, rd, e, lat);
        n_checks++; if (e !== 1'b0) $display("FAIL be_store_err got=%b exp=0", e); else n_pass++;
        txn(1'b0, 1'b0, 32'h8, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (rd !== 32'hAA22_CC44) $display("FAIL be_merge got=%h exp=aa22cc44", rd); else n_pass++;
    endtask

    task automatic test_faults();
        logic [31:0] rd; logic e; int lat;
        txn(1'b0, 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, e, lat);
        txn(1'b0, 1'b0, 32'h6, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (e !== 1'b1) $display("FAIL misalign_err got=%b exp=1", e); else n_pass++;
        n_checks++; if (rd !== 32'h0) $display("FAIL misalign_rdata got=%h exp=0", rd); else n_pass++;
        txn(1'b0, 1'b1, 32'h1000, 32'hFFFF_FFFF, 4'hF, rd, e, lat);
        n_checks++; if (e !== 1'b1) $display("FAIL range_err got=%b exp=1", e); else n_pass++;
        txn(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (rd !== 32'hCAFE_F00D || e !== 1'b0) $display("FAIL range_no_write got=%h err=%b exp=cafef00d err=0", rd, e); else n_pass++;
        txn(1'b0, 1'b1, 32'h4, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (e !== 1'b0) $display("FAIL be0_err got=%b exp=0", e); else n_pass++;
        txn(1'b0, 1'b0, 32'h4, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (rd !== 32'h1234_5678) $display("FAIL be0_noop got=%h exp=12345678", rd); else n_pass++;
    endtask

    task automatic test_busy_reject();
        int c0, c1, pulses; logic [31:0] last_rd, rd; logic e; int lat;
        run_held(1'b0, 1'b1, 32'h10, 32'h0101_0101, 1'b1, 32'h14, 32'h0202_0202, c0, c1, pulses, last_rd);
        n_checks++; if (c0 !== 0 || c1 !== 3) $display("FAIL busy_accept_cycles got=%0d,%0d exp=0,3", c0, c1); else n_pass++;
        n_checks++; if (pulses !== 2) $display("FAIL busy_pulses got=%0d exp=2", pulses); else n_pass++;
        txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (rd !== 32'h0101_0101) $display("FAIL busy_first got=%h exp=01010101", rd); else n_pass++;
        txn(1'b0, 1'b0, 32'h14, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (rd !== 32'h0202_0202) $display("FAIL busy_second got=%h exp=02020202", rd); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic e; int lat; logic seen;
        seen = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'hC, 32'hDEAD_BEEF, 4'hF);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        if (rvalid_a) seen = 1'b1;
        @(negedge clk); reset = 1'b0; #1;
        n_checks++; if (ready_a !== 1'b0 || st_a !== 2'd0) $display("FAIL midrst_outputs ready=%b state=%0d exp 0,0", ready_a, st_a); else n_pass++;
        repeat (2) begin
            @(posedge clk); #1;
            if (rvalid_a) seen = 1'b1;
        end
        @(negedge clk); reset = 1'b1; #1;
        n_checks++; if (ready_a !== 1'b1) $display("FAIL midrst_release_ready got=%b exp=1", ready_a); else n_pass++;
        n_checks++; if (seen !== 1'b0) $display("FAIL midrst_rvalid got=1 exp=0"); else n_pass++;
        @(posedge clk); #1;
        txn(1'b0, 1'b0, 32'hC, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (rd !== 32'h0) $display("FAIL midrst_no_write got=%h exp=0", rd); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic e; int lat;
        int c0, c1, pulses; logic [31:0] last_rd;
        txn(1'b1, 1'b1, 32'h20, 32'h55AA_55AA, 4'hF, rd, e, lat);
        n_checks++; if (lat !== 1) $display("FAIL l1_st_latency got=%0d exp=1", lat); else n_pass++;
        txn(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (lat !== 1 || rd !== 32'h55AA_55AA) $display("FAIL l1_ld lat=%0d rdata=%h exp 1,55aa55aa", lat, rd); else n_pass++;
        txn(1'b1, 1'b1, 32'h24, 32'h0BAD_F00D, 4'b1000, rd, e, lat);
        txn(1'b1, 1'b0, 32'h24, 32'h0, 4'h0, rd, e, lat);
        n_checks++; if (rd !== 32'h0B00_0000 || e !== 1'b0) $display("FAIL l1_be_ld got=%h err=%b exp=0b000000 err=0", rd, e); else n_pass++;
        run_held(1'b1, 1'b1, 32'h28, 32'h1357_9BDF, 1'b0, 32'h28, 32'h0, c0, c1, pulses, last_rd);
        n_checks++; if (c0 !== 0 || c1 !== 2) $display("FAIL l1_accept_cycles got=%0d,%0d exp=0,2", c0, c1); else n_pass++;
        n_checks++; if (pulses !== 2) $display("FAIL l1_pulses got=%0d exp=2", pulses); else n_pass++;
        n_checks++; if (last_rd !== 32'h1357_9BDF) $display("FAIL l1_held_ld got=%h exp=13579bdf", last_rd); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enables();
        test_faults();
        test_busy_reject();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
